q_resolver_core: RTL and testbench

- Q-flop-style resolver. Samples a possibly asynchronous single-bit `data` input on `clock`.
- Passes it through a synchroniser chain, then declares the bit resolved only after the synchronised value has held stable for a programmable number of cycles.
- Reports the result on two active-low, mutually exclusive flags: `rh_l` (resolved high) and `rl_l` (resolved low). Both flags high means "unresolved".
- Sits at the boundary between asynchronous sources and Q-flop pipeline stages.

---
 rtl/q_pkg.sv | 12 +
 rtl/q_sync_chain.sv | 25 ++
 rtl/q_resolver_core.sv | 100 ++++++++++
 tb/tb_q_resolver_core.sv | 132 +++++++++++++
 4 files changed

// File: rtl/q_pkg.sv
// Shared constants and the internal resolution-state encoding for the Q-flop resolver.
package q_pkg;
    localparam int Q_SYNC_STAGES_DEF = 2;
    localparam int Q_HOLD_CYCLES_DEF = 2;
    localparam int Q_TIMEOUT_DEF     = 16;

    typedef enum logic [1:0] {
        Q_UNRES = 2'd0,
        Q_HIGH  = 2'd1,
        Q_LOW   = 2'd2
    } q_res_t;
endpackage

// File: rtl/q_sync_chain.sv
// Reset-clearable synchroniser flop chain; kept as its own module so the flops can be
// constrained as a unit. sync_q[0] is the first stage, sync_q[SYNC_STAGES-1] the last.
module q_sync_chain
    import q_pkg::*;
#(
    parameter int SYNC_STAGES = Q_SYNC_STAGES_DEF
) (
    input  logic                   clock,
    input  logic                   reset_l,
    input  logic                   d,
    output logic [SYNC_STAGES-1:0] q
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) sync_q <= '0;
        else          sync_q <= sync_d;
    end

    assign q = sync_q;
endmodule

// File: rtl/q_resolver_core.sv
// Q-flop resolver: synchronise data, then flag it resolved once L = SYNC_STAGES+HOLD_CYCLES
// consecutive samples agree. Optional timeout output under `define Q_RESOLVER_TIMEOUT_EN.
module q_resolver_core
    import q_pkg::*;
#(
    parameter int SYNC_STAGES    = Q_SYNC_STAGES_DEF,
    parameter int HOLD_CYCLES    = Q_HOLD_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = Q_TIMEOUT_DEF
) (
    input  logic clock,
    input  logic reset_l,
    input  logic data,
`ifdef Q_RESOLVER_TIMEOUT_EN
    output logic to_l,
`endif
    output logic rh_l,
    output logic rl_l
);
    localparam int L  = SYNC_STAGES + HOLD_CYCLES;
    localparam int FW = $clog2(L + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(L);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_nxt;
    logic [HOLD_CYCLES-1:0] hist_q, hist_d;
    logic [L-1:0]           win_d;
    logic [FW-1:0]          fill_q, fill_d;
    q_res_t                 res_q, res_d;

    q_sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock   (clock),
        .reset_l (reset_l),
        .d       (data),
        .q       (sync_q)
    );

    // Mirror of the chain's next state so flags reflect the post-shift window.
    assign sync_nxt = {sync_q[SYNC_STAGES-2:0], data};

    if (HOLD_CYCLES == 1) begin : g_hist1
        assign hist_d = sync_q[SYNC_STAGES-1];
    end else begin : g_histn
        assign hist_d = {hist_q[HOLD_CYCLES-2:0], sync_q[SYNC_STAGES-1]};
    end

    always_comb begin
        win_d  = {hist_d, sync_nxt};
        fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
        res_d  = Q_UNRES;
        if (fill_d == FILL_MAX) begin
            if (&win_d)       res_d = Q_HIGH;
            else if (~|win_d) res_d = Q_LOW;
        end
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            hist_q <= '0;
            fill_q <= '0;
            res_q  <= Q_UNRES;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            res_q  <= res_d;
        end
    end

    // Single encoded state guarantees the two flags can never be low together.
    assign rh_l = (res_q != Q_HIGH);
    assign rl_l = (res_q != Q_LOW);

`ifdef Q_RESOLVER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] ucnt_q, ucnt_d;
    logic          to_l_q, to_l_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (res_q != Q_UNRES)
            ucnt_d = '0;
        else if (fill_q == FILL_MAX && ucnt_q != TO_MAX)
            ucnt_d = ucnt_q + CW'(1);
        to_l_d = (res_d != Q_UNRES) ? 1'b1 : (ucnt_d != TO_MAX);
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            ucnt_q <= '0;
            to_l_q <= 1'b1;
        end else begin
            ucnt_q <= ucnt_d;
            to_l_q <= to_l_d;
        end
    end

    assign to_l = to_l_q;
`endif
endmodule

// File: tb/tb_q_resolver_core.sv
// Directed bench for q_resolver_core with SYNC_STAGES=2, HOLD_CYCLES=2 (L=4).
module tb_q_resolver_core;
    logic clock, reset_l, data, rh_l, rl_l;
`ifdef Q_RESOLVER_TIMEOUT_EN
    logic to_l;
`endif
    int n_tests = 0;
    int n_fail  = 0;

    q_resolver_core #(.SYNC_STAGES(2), .HOLD_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
        .clock   (clock),
        .reset_l (reset_l),
        .data    (data),
`ifdef Q_RESOLVER_TIMEOUT_EN
        .to_l    (to_l),
`endif
        .rh_l    (rh_l),
        .rl_l    (rl_l)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // One rising edge, then sample 1 time unit later; exclusivity checked every edge.
    task automatic tick();
        @(posedge clock);
        #1;
        chk("excl", rh_l | rl_l, 1'b1);
    endtask

    task automatic flags(input string tag, input logic exp_rh, input logic exp_rl);
        chk({tag, "_rh"}, rh_l, exp_rh);
        chk({tag, "_rl"}, rl_l, exp_rl);
    endtask

    initial begin
        reset_l = 1'b0;
        data    = 1'b1;
        #3;
        flags("rst_noclk", 1'b1, 1'b1);

        @(negedge clock);
        reset_l = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            flags("fill", 1'b1, 1'b1);
        end
        tick();
        flags("res_hi", 1'b0, 1'b1);

        // Transition to 0: high drops on edge e, low asserts after e+3
        data = 1'b0;
        for (int i = 0; i <= 2; i++) begin
            tick();
            flags("trans_unres", 1'b1, 1'b1);
        end
        tick();
        flags("res_lo", 1'b1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            data = (i % 2 == 0);
            tick();
            flags("toggle", 1'b1, 1'b1);
        end

        // Glitch: single 0 inside a run of 1s
        data = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        flags("pre_glitch", 1'b0, 1'b1);
        data = 1'b0;
        tick();
        flags("glitch_z", 1'b1, 1'b1);
        data = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            flags("glitch_hold", 1'b1, 1'b1);
        end
        tick();
        flags("glitch_rehi", 1'b0, 1'b1);

        // Reset between edges after two stable zeros
        data = 1'b0;
        tick();
        tick();
        #2;
        reset_l = 1'b0;
        #1;
        flags("midrst", 1'b1, 1'b1);
        reset_l = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            flags("midrst_fill", 1'b1, 1'b1);
        end
        tick();
        flags("midrst_lo", 1'b1, 1'b0);

`ifdef Q_RESOLVER_TIMEOUT_EN
        #2;
        reset_l = 1'b0;
        #1;
        chk("to_rst", to_l, 1'b1);
        reset_l = 1'b1;
        // Counting starts at edge 5 (first edge with a full window), so to_l drops after edge 20
        for (int i = 1; i <= 20; i++) begin
            data = (i % 2 == 1);
            tick();
            chk("to_toggle", to_l, (i == 20) ? 1'b0 : 1'b1);
        end
        data = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("to_hold", to_l, 1'b0);
        end
        tick();
        chk("to_clear", to_l, 1'b1);
        flags("to_res_hi", 1'b0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
